// File: rtl/xalu_pkg.sv
// Shared definitions for the nibble-serial ALU word sequencer.
// Holds the op codes, the FSM state type and the slice width.
package xalu_pkg;

    localparam int NIB_W = 4;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_PASSA = 3'd4;
    localparam logic [2:0] OP_PASSB = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_SHL   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/xalu_slice_core.sv
// Purely combinational 4-bit ALU slice; the sequencer chains carries and
// shift bits between successive nibbles around it.
module xalu_slice_core
    import xalu_pkg::*;
(
    input  logic [NIB_W-1:0] da,
    input  logic [NIB_W-1:0] db,
    input  logic             ci_left,
    input  logic             ci_right,
    input  logic [2:0]       op,
    input  logic             com,
    output logic [NIB_W-1:0] d,
    output logic             co_left,
    output logic             co_right,
    output logic             equ,
    output logic             zero,
    output logic             neg_zero
);

    logic [NIB_W:0]   w_sum;
    logic [NIB_W-1:0] w_raw;

    assign w_sum = {1'b0, da} + {1'b0, db} + {{NIB_W{1'b0}}, ci_right};

    // SHR pulls its top bit from the left neighbour; SHL its bottom bit from the right.
    always_comb begin
        w_raw    = da;
        co_left  = 1'b0;
        co_right = 1'b0;
        case (op)
            OP_ADD: begin
                w_raw   = w_sum[NIB_W-1:0];
                co_left = w_sum[NIB_W];
            end
            OP_AND:   w_raw = da & db;
            OP_OR:    w_raw = da | db;
            OP_XOR:   w_raw = da ^ db;
            OP_PASSA: w_raw = da;
            OP_PASSB: w_raw = db;
            OP_SHR: begin
                w_raw    = {ci_left, da[NIB_W-1:1]};
                co_right = da[0];
            end
            OP_SHL: begin
                w_raw   = {da[NIB_W-2:0], ci_right};
                co_left = da[NIB_W-1];
            end
        endcase
    end

    assign d        = com ? ~w_raw : w_raw;
    assign equ      = (da == db);
    assign zero     = (d == '0);
    assign neg_zero = (d == '1);

endmodule

// File: rtl/xalu_word_sequencer.sv
// Multi-cycle controller building a 4*NIBBLES-bit ALU operation from one
// 4-bit slice, processing one nibble per enabled clock.
module xalu_word_sequencer
    import xalu_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic                       com,
    input  logic                       cin,
    input  logic [NIB_W*NIBBLES-1:0]   a,
    input  logic [NIB_W*NIBBLES-1:0]   b,
    output logic                       busy,
    output logic                       done,
    output logic [NIB_W*NIBBLES-1:0]   result,
    output logic                       cout,
    output logic                       zero,
    output logic                       neg_zero,
    output logic                       equ
);

    localparam int W   = NIB_W * NIBBLES;
    localparam int IW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int BWA = $clog2(W + 2);
    localparam int BWB = $clog2(W);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t          r_state;
    logic [2:0]      r_op;
    logic            r_com;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [IW-1:0]   r_idx;
    logic            r_zAcc;
    logic            r_nzAcc;
    logic            r_eqAcc;
    logic [W-1:0]    r_result;
    logic            r_cout;
    logic            r_zero;
    logic            r_negZero;
    logic            r_equ;
    logic            r_busy;
    logic            r_done;

    logic [IW-1:0]     w_k;
    logic [BWA-1:0]    w_baseA;
    logic [BWB-1:0]    w_baseB;
    logic [W+1:0]      w_aExt;
    logic [NIB_W+1:0]  w_aWin;
    logic [NIB_W-1:0]  w_d;
    logic              w_coLeft;
    logic              w_coRight;
    logic              w_equ;
    logic              w_zero;
    logic              w_negZero;
    logic              w_ciRight;

    assign w_k     = (r_op == OP_SHR) ? (LAST - r_idx) : r_idx;
    assign w_baseA = BWA'(NIB_W * int'(w_k));
    assign w_baseB = BWB'(NIB_W * int'(w_k));

    // The carry register doubles as the fill bit at both word ends; it only
    // changes during ADD, so for shifts it still holds the latched cin.
    assign w_aExt    = {r_carry, r_a, r_carry};
    assign w_aWin    = w_aExt[w_baseA +: NIB_W + 2];
    assign w_ciRight = (r_op == OP_ADD) ? r_carry : w_aWin[0];

    xalu_slice_core u_slice (
        .da       (w_aWin[NIB_W:1]),
        .db       (r_b[w_baseB +: NIB_W]),
        .ci_left  (w_aWin[NIB_W+1]),
        .ci_right (w_ciRight),
        .op       (r_op),
        .com      (r_com),
        .d        (w_d),
        .co_left  (w_coLeft),
        .co_right (w_coRight),
        .equ      (w_equ),
        .zero     (w_zero),
        .neg_zero (w_negZero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= OP_ADD;
            r_com     <= 1'b0;
            r_carry   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_zAcc    <= 1'b0;
            r_nzAcc   <= 1'b0;
            r_eqAcc   <= 1'b0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_zero    <= 1'b0;
            r_negZero <= 1'b0;
            r_equ     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_com    <= com;
                        r_a      <= a;
                        r_b      <= b;
                        r_carry  <= cin;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_zAcc   <= 1'b1;
                        r_nzAcc  <= 1'b1;
                        r_eqAcc  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_result[w_baseB +: NIB_W] <= w_d;
                    if (r_op == OP_ADD) begin
                        r_carry <= w_coLeft;
                    end
                    r_zAcc  <= r_zAcc & w_zero;
                    r_nzAcc <= r_nzAcc & w_negZero;
                    r_eqAcc <= r_eqAcc & w_equ;
                    r_idx   <= r_idx + IW'(1);
                    // Last nibble processed for SHL is the MSB and for SHR the LSB,
                    // so the slice's shifted-out bit is exactly the word's.
                    if (r_idx == LAST) begin
                        r_zero    <= r_zAcc & w_zero;
                        r_negZero <= r_nzAcc & w_negZero;
                        r_equ     <= r_eqAcc & w_equ;
                        case (r_op)
                            OP_ADD, OP_SHL: r_cout <= w_coLeft;
                            OP_SHR:         r_cout <= w_coRight;
                            default:        r_cout <= 1'b0;
                        endcase
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign zero     = r_zero;
    assign neg_zero = r_negZero;
    assign equ      = r_equ;

endmodule

// File: tb/tb_xalu_word_sequencer.sv
// Self-checking bench for xalu_word_sequencer: whole-word reference model,
// directed corner cases and randomized operations.
module tb_xalu_word_sequencer;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         ena      = 1'b1;
    logic         start    = 1'b0;
    logic [2:0]   op       = 3'd0;
    logic         com      = 1'b0;
    logic         cin      = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         neg_zero;
    logic         equ;

    int checks   = 0;
    int failures = 0;

    logic         pending = 1'b0;
    logic [W-1:0] expResult;
    logic         expCout, expZero, expNegZero, expEqu;
    logic [W-1:0] capResult;
    logic         capCout, capZero, capNegZero, capEqu;

    xalu_word_sequencer #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .op       (op),
        .com      (com),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .zero     (zero),
        .neg_zero (neg_zero),
        .equ      (equ)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Whole-word semantics: the nibble decomposition must be invisible here.
    function automatic void modelOp(input logic [2:0] mOp, input logic mCom, input logic mCin,
                                    input logic [W-1:0] mA, input logic [W-1:0] mB,
                                    output logic [W-1:0] r, output logic c, output logic z,
                                    output logic nz, output logic e);
        logic [W:0] s;
        c = 1'b0;
        r = '0;
        case (mOp)
            3'd0: begin
                s = {1'b0, mA} + {1'b0, mB} + {{W{1'b0}}, mCin};
                r = s[W-1:0];
                c = s[W];
            end
            3'd1: r = mA & mB;
            3'd2: r = mA | mB;
            3'd3: r = mA ^ mB;
            3'd4: r = mA;
            3'd5: r = mB;
            3'd6: begin
                r = {mCin, mA[W-1:1]};
                c = mA[0];
            end
            3'd7: begin
                r = {mA[W-2:0], mCin};
                c = mA[W-1];
            end
        endcase
        if (mCom) r = ~r;
        z  = (r == '0);
        nz = (r == '1);
        e  = (mA == mB);
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (pending) begin
                checkOutput("result",   32'(result),   32'(expResult));
                checkOutput("cout",     32'(cout),     32'(expCout));
                checkOutput("zero",     32'(zero),     32'(expZero));
                checkOutput("neg_zero", 32'(neg_zero), 32'(expNegZero));
                checkOutput("equ",      32'(equ),      32'(expEqu));
                capResult  = result;
                capCout    = cout;
                capZero    = zero;
                capNegZero = neg_zero;
                capEqu     = equ;
                pending    = 1'b0;
            end else begin
                checkOutput("spurious_done", 32'(done), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] tOp, input logic tCom, input logic tCin,
                                 input logic [W-1:0] tA, input logic [W-1:0] tB,
                                 input int interruptAt, input int stallAt, input int stallLen,
                                 input bit startInDone);
        int lat;
        bit seen;
        @(negedge clk);
        op    = tOp;
        com   = tCom;
        cin   = tCin;
        a     = tA;
        b     = tB;
        ena   = 1'b1;
        start = 1'b1;
        modelOp(tOp, tCom, tCin, tA, tB, expResult, expCout, expZero, expNegZero, expEqu);
        pending = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == 1) checkOutput("busy_run", 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (lat == interruptAt) begin
                start = 1'b1;
                op    = 3'd3;
                a     = ~tA;
            end
            if (lat == stallAt) ena = 1'b0;
            if (lat == stallAt + stallLen) ena = 1'b1;
        end
        ena = 1'b1;
        if (!seen) begin
            checkOutput("done_timeout", 32'(seen), 32'd1);
            pending = 1'b0;
        end else begin
            checkOutput("latency", 32'(lat - 1), 32'(NIB + ((stallAt >= 0) ? stallLen : 0)));
        end
        if (startInDone) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_pulse",  32'(done),   32'd0);
        checkOutput("idle_busy",   32'(busy),   32'd0);
        checkOutput("result_hold", 32'(result), 32'(expResult));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},     32'(busy),     32'd0);
        checkOutput({tag, "_done"},     32'(done),     32'd0);
        checkOutput({tag, "_result"},   32'(result),   32'd0);
        checkOutput({tag, "_cout"},     32'(cout),     32'd0);
        checkOutput({tag, "_zero"},     32'(zero),     32'd0);
        checkOutput({tag, "_neg_zero"}, 32'(neg_zero), 32'd0);
        checkOutput({tag, "_equ"},      32'(equ),      32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        #1 rst_n = 1'b0;
        #2 checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(3'd0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, -1, -1, 0, 1'b0);
        checkOutput("t1_result", 32'(capResult), 32'h8000);
        checkOutput("t1_cout",   32'(capCout),   32'd0);
        checkOutput("t1_zero",   32'(capZero),   32'd0);
        checkOutput("t1_equ",    32'(capEqu),    32'd0);

        applyStimulus(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, -1, -1, 0, 1'b1);
        checkOutput("t2_result",   32'(capResult),  32'h0000);
        checkOutput("t2_cout",     32'(capCout),    32'd1);
        checkOutput("t2_zero",     32'(capZero),    32'd1);
        checkOutput("t2_neg_zero", 32'(capNegZero), 32'd0);

        applyStimulus(3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000, -1, -1, 0, 1'b0);
        checkOutput("t3_shl_result", 32'(capResult), 32'h0003);
        checkOutput("t3_shl_cout",   32'(capCout),   32'd1);
        applyStimulus(3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000, -1, -1, 0, 1'b0);
        checkOutput("t3_shr_result", 32'(capResult), 32'h4000);
        checkOutput("t3_shr_cout",   32'(capCout),   32'd1);

        applyStimulus(3'd3, 1'b0, 1'b0, 16'h1234, 16'h1234, -1, -1, 0, 1'b0);
        checkOutput("t4_result", 32'(capResult), 32'h0000);
        checkOutput("t4_zero",   32'(capZero),   32'd1);
        checkOutput("t4_equ",    32'(capEqu),    32'd1);
        applyStimulus(3'd3, 1'b1, 1'b0, 16'h1234, 16'h1234, -1, -1, 0, 1'b0);
        checkOutput("t4c_result",   32'(capResult),  32'hFFFF);
        checkOutput("t4c_neg_zero", 32'(capNegZero), 32'd1);
        checkOutput("t4c_zero",     32'(capZero),    32'd0);

        applyStimulus(3'd0, 1'b0, 1'b1, 16'h1357, 16'h2468, 2, -1, 0, 1'b0);
        checkOutput("t5_result", 32'(capResult), 32'h37C0);
        applyStimulus(3'd0, 1'b0, 1'b0, 16'h1357, 16'h2468, -1, 2, 3, 1'b0);
        checkOutput("t5s_result", 32'(capResult), 32'h37BF);

        // Abandon an ADD mid-RUN with an asynchronous reset.
        @(negedge clk);
        op    = 3'd0;
        a     = 16'h0F0F;
        b     = 16'h0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkAllZero("t6");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t6_no_done_in_reset", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            checkOutput("t6_no_done_after", 32'(done), 32'd0);
        end
        applyStimulus(3'd0, 1'b0, 1'b0, 16'h0F0F, 16'h0101, -1, -1, 0, 1'b0);
        checkOutput("t6_restart_result", 32'(capResult), 32'h1010);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ra, rb, -1, -1, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
